// File: rtl/dot_pkg.sv
// Shared types and default constants for the dot-product initiator path.
package dot_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } feed_state_t;

    localparam int DOT_Q       = 15;
    localparam int DOT_N       = 32;
    localparam int DOT_H       = 10;
    localparam int DOT_TIMEOUT = 64;

endpackage

// File: rtl/dot_wait_timer.sv
// Completion watchdog: counts WAIT cycles and flags the last permitted one.
module dot_wait_timer
    import dot_pkg::*;
#(
    parameter int TIMEOUT = DOT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Holds at the terminal value so a stalled enable can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dot_vector_feeder.sv
// Collects (a,b) pairs into two vectors, fires the dot engine, returns the result.
//  state | meaning
//  LOAD  | accepting pairs into a_vec/b_vec at idx
//  FIRE  | one-cycle start_dot pulse, watchdog cleared
//  WAIT  | vectors frozen, waiting for dot_done or watchdog expiry
//  OUT   | result (or timeout error) offered until consumer takes it
module dot_vector_feeder
    import dot_pkg::*;
#(
    parameter int Q       = DOT_Q,
    parameter int N       = DOT_N,
    parameter int H       = DOT_H,
    parameter int TIMEOUT = DOT_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [N-1:0]        in_a_i,
    input  logic [N-1:0]        in_b_i,
    input  logic                in_last_i,
    output logic [H-1:0][N-1:0] a_vec_o,
    output logic [H-1:0][N-1:0] b_vec_o,
    output logic                start_dot_o,
    input  logic [N-1:0]        dot_result_i,
    input  logic                dot_done_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [N-1:0]        out_data_o,
    output logic                out_err_o
);

    localparam int IDX_W = $clog2(H);

    if (H < 2) begin : g_bad_h
        $error("dot_vector_feeder: H must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dot_vector_feeder: TIMEOUT must be at least 1");
    end
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("dot_vector_feeder: Q must lie in [0, N-1]");
    end

    feed_state_t         state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [H-1:0][N-1:0] a_q;
    logic [H-1:0][N-1:0] b_q;
    logic                start_q;
    logic                out_valid_q;
    logic [N-1:0]        out_data_q;
    logic                out_err_q;

    logic                last_xfer;
    logic                timer_expired;

    assign last_xfer   = in_last_i || (idx_q == IDX_W'(H - 1));

    assign in_ready_o  = (state_q == LOAD);
    assign a_vec_o     = a_q;
    assign b_vec_o     = b_q;
    assign start_dot_o = start_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_err_o   = out_err_q;

    dot_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == FIRE),
        .en_i      (state_q == WAIT),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (in_valid_i) begin
                        // Slots above an early last are zeroed so stale data never reaches the engine.
                        for (int j = 0; j < H; j++) begin
                            if (j == int'(idx_q)) begin
                                a_q[j] <= in_a_i;
                                b_q[j] <= in_b_i;
                            end else if (last_xfer && (j > int'(idx_q))) begin
                                a_q[j] <= '0;
                                b_q[j] <= '0;
                            end
                        end
                        if (last_xfer) begin
                            state_q <= FIRE;
                            start_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                FIRE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (dot_done_i) begin
                        out_data_q  <= dot_result_i;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (timer_expired) begin
                        out_data_q  <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

endmodule
